// File: rtl/booth_mult.sv
// Sequential signed multiplier using radix-2 Booth recoding, one add/sub/shift step per clock.
// Operands are captured on start; the result is registered and flagged by a one-cycle done pulse.
module booth_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [WIDTH:0]    a_q;
  logic [WIDTH:0]    m_q;
  logic [WIDTH-1:0]  q_q;
  logic              qm1_q;
  logic [CntW-1:0]   cnt_q;

  logic [WIDTH:0]    a_sum;
  logic [WIDTH:0]    a_shift;
  logic [WIDTH-1:0]  q_shift;
  logic              qm1_shift;

  // A is one bit wider than the operands so adding/subtracting the most negative M cannot overflow.
  always_comb begin
    a_sum = a_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    {a_shift, q_shift, qm1_shift} = {a_sum[WIDTH], a_sum, q_q};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            m_q     <= {multiplicand[WIDTH-1], multiplicand};
            q_q     <= multiplier;
            a_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= CntW'(WIDTH);
            busy    <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          a_q   <= a_shift;
          q_q   <= q_shift;
          qm1_q <= qm1_shift;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          product <= {a_q[WIDTH-1:0], q_q};
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: cycle-level behavioural model compared every cycle,
// directed cases with literal results, then randomized traffic including stray starts and resets.
module tb_booth_mult;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   mc = '0;
  logic [W-1:0]   mp = '0;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  booth_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (mc),
    .multiplier   (mp),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  function automatic logic [2*W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    return (2*W)'(sa * sb);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted op completes WIDTH+1 edges later with the plain signed product.
  bit             m_busy = 1'b0;
  bit             m_done = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_exp = '0;
  int             m_rem = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_prod = '0;
      m_rem  = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_rem  = W + 1;
          m_exp  = mul(mc, mp);
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_prod = m_exp;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("product", 32'(product), 32'(m_prod));
    end
  end

  // Waits (bounded) for done; reports edges elapsed and busy cycles seen.
  task automatic wait_done(output int edges, output int busy_cnt, output bit seen);
    edges = 0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      mc = W'($urandom);
      mp = W'($urandom);
      edges++;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] lit, input string name);
    int edges;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    mc = a;
    mp = b;
    wait_done(edges, busy_cnt, seen);
    check({name, " seen"}, 32'(seen), 32'd1);
    check({name, " product"}, 32'(product), 32'(lit));
    check({name, " edges"}, 32'(edges), 32'd10);
    check({name, " busy cycles"}, 32'(busy_cnt), 32'd9);
  endtask

  initial begin
    int edges;
    int busy_cnt;
    int nd;
    int t0;
    int t1;
    int cyc;
    bit seen;
    logic [2*W-1:0] p0;
    logic [2*W-1:0] p1;

    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset product", 32'(product), 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    // First edge with reset released already accepts start.
    reset = 1'b1;
    start = 1'b1;
    mc = 8'd3;
    mp = 8'hFB;
    wait_done(edges, busy_cnt, seen);
    check("post-reset accept product", 32'(product), 32'h0000FFF1);
    check("post-reset accept edges", 32'(edges), 32'd10);

    run_op(8'd7, 8'd3, 16'h0015, "7*3");
    run_op(8'hF8, 8'd2, 16'hFFF0, "-8*2");
    run_op(8'hF8, 8'hFE, 16'h0010, "-8*-2");
    run_op(8'h80, 8'h80, 16'h4000, "-128*-128");
    run_op(8'h7F, 8'h80, 16'hC080, "127*-128");
    run_op(8'h00, 8'h80, 16'h0000, "0*-128");

    // Stray start during CALC is ignored.
    @(negedge clk);
    start = 1'b1;
    mc = 8'd5;
    mp = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    mc = 8'd9;
    mp = 8'd9;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    p0 = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      mc = W'($urandom);
      mp = W'($urandom);
      if (done) begin
        nd++;
        p0 = product;
      end
    end
    check("ignored start done count", 32'(nd), 32'd1);
    check("ignored start product", 32'(p0), 32'h19);

    // Reset mid-operation abandons it.
    @(negedge clk);
    start = 1'b1;
    mc = 8'd10;
    mp = 8'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort product", 32'(product), 32'd0);
    reset = 1'b1;
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort no done", 32'(nd), 32'd0);

    // start held high: back-to-back operations.
    @(negedge clk);
    start = 1'b1;
    mc = 8'd3;
    mp = 8'd4;
    @(negedge clk);
    mc = 8'd6;
    mp = 8'hFF;
    nd = 0;
    cyc = 0;
    t0 = 0;
    t1 = 0;
    p0 = '0;
    p1 = '0;
    for (int k = 0; k < 40 && nd < 2; k++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (nd == 0) begin
          p0 = product;
          t0 = cyc;
        end else begin
          p1 = product;
          t1 = cyc;
          start = 1'b0;
        end
        nd++;
      end
    end
    check("b2b count", 32'(nd), 32'd2);
    check("b2b first", 32'(p0), 32'h000C);
    check("b2b second", 32'(p1), 32'hFFFA);
    check("b2b spacing", 32'(t1 - t0), 32'd10);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0: mc = 8'h80;
          1: mc = 8'h7F;
          2: mc = 8'hFF;
          3: mc = 8'h00;
          default: mc = 8'h01;
        endcase
      end else begin
        mc = W'($urandom);
      end
      mp = ($urandom_range(0, 3) == 0) ? 8'h80 : W'($urandom);
      reset = ($urandom_range(0, 149) != 0);
    end
    reset = 1'b1;
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
